ysyx_24100005_mem_responder: RTL
================================

YSYX_24100005_MEM_RESPONDER -- requirements
Module: ysyx_24100005_mem_responder

Interface
- REQ-001: Parameter ADDR_BASE, default 32'h8000_0000, first byte address of the memory window.
- REQ-002: Parameter DEPTH_LOG2, default 10, log2 of the number of 32-bit words stored.
- REQ-003: Parameter LATENCY, default 2, cycles from request accept to access (legal range 1..15).
- REQ-004: clk  input  1  single clock; all state updates on the rising edge.
- REQ-005: rst  input  1  asynchronous, active-high reset.
- REQ-006: req_valid  input  1  initiator presents a request.
- REQ-007: req_ready  output  1  responder can accept a request.
- REQ-008: req_wen  input  1  1 = store, 0 = load.
- REQ-009: req_addr  input  32  byte address.
- REQ-010: req_wdata  input  32  store data.
- REQ-011: req_wmask  input  4  store byte enables; bit i enables byte i.
- REQ-012: rsp_valid  output  1  response presented.
- REQ-013: rsp_ready  input  1  initiator accepts the response.
- REQ-014: rsp_rdata  output  32  load data; 0 for stores and errors.
- REQ-015: rsp_err  output  1  address outside the window.

Function
- REQ-016: FSM states: IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
- REQ-017: In IDLE, req_valid && req_ready at an edge SHALL capture wen, addr, wdata, wmask, load the counter with LATENCY-1 and enter WAIT.
- REQ-018: In WAIT with counter != 0, the counter SHALL decrement each edge.
- REQ-019: In WAIT with counter == 0, the next edge SHALL perform the access, register rsp_rdata/rsp_err and enter RESP.
- REQ-020: rsp_valid SHALL be 1 exactly in RESP; for a request accepted at edge T, rsp_valid rises after edge T+LATENCY.
- REQ-021: rsp_valid, rsp_rdata and rsp_err SHALL hold stable in RESP until rsp_ready is 1 at an edge; that edge SHALL return to IDLE.
- REQ-022: No new request is accepted in the cycle of the response handshake; minimum spacing is LATENCY+2 cycles per transaction.
- REQ-023: In window: ADDR_BASE <= addr < ADDR_BASE + 4*2^DEPTH_LOG2; word index = (addr - ADDR_BASE) >> 2; addr[1:0] are ignored.
- REQ-024: Load in window: rsp_rdata = stored word, rsp_err = 0.
- REQ-025: Store in window: each byte i with wmask[i]=1 is replaced by wdata byte i, other bytes unchanged; rsp_rdata = 0, rsp_err = 0.
- REQ-026: Store with wmask = 4'b0000: memory unchanged, normal response.
- REQ-027: Out-of-window access: no memory change, rsp_rdata = 0, rsp_err = 1.
- REQ-028: Request inputs outside the IDLE accept edge SHALL be ignored; changes during WAIT/RESP do not affect the transaction.
- REQ-029: Memory write occurs only at the WAIT->RESP edge, once per store.

Reset
- REQ-030: rst = 1 SHALL immediately force IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 1.
- REQ-031: Reset in WAIT SHALL abandon the transaction with no memory write; reset in RESP drops the response.
- REQ-032: Memory array contents are not cleared by reset; after deassertion the first edge may accept a request.

Verification (LATENCY=2, DEPTH_LOG2=10)
- REQ-033: Store addr 0x8000_0010, wdata 0xDEAD_BEEF, wmask 4'hF, then load same addr -> store: rsp_err 0, rdata 0; load: rdata 0xDEAD_BEEF; rsp_valid rises 2 edges after accept each time.
- REQ-034: After REQ-033, store wdata 0x1122_3344 wmask 4'b0101 at 0x8000_0010, load -> rdata 0xDE22_BE44.
- REQ-035: Load addr 0x8000_1000 (one past window) and 0x7FFF_FFFC -> rsp_err 1, rdata 0; memory unchanged.
- REQ-036: Hold rsp_ready 0 for 5 cycles in RESP while changing req_* -> rsp_valid/rdata stable, req_ready 0; accept occurs only after handshake and return to IDLE.
- REQ-037: Store 0x0000_00AA to 0x8000_0020 with rst pulsed in WAIT -> rsp_valid 0, req_ready 1 immediately; later load returns prior contents.
- REQ-038: LATENCY=1 build, back-to-back requests with rsp_ready tied 1 -> rsp_valid after 1 edge, one transaction per 3 cycles.

Source files
------------

// File: rtl/ysyx_24100005_mem_responder.sv
// ysyx_24100005_mem_responder
//
// Single-port word memory behind a valid/ready request channel and a
// valid/ready response channel. One transaction is in flight at a time:
// a request is captured in IDLE, held for LATENCY cycles in WAIT, then the
// access is performed and the response is presented in RESP until taken.
//
// Ports
//   clk        in   1   clock, all state updates on rising edge
//   rst        in   1   asynchronous active-high reset
//   req_valid  in   1   request present
//   req_ready  out  1   responder idle and able to accept
//   req_wen    in   1   1 = store, 0 = load
//   req_addr   in  32   byte address
//   req_wdata  in  32   store data
//   req_wmask  in   4   store byte enables (bit i -> byte i)
//   rsp_valid  out  1   response present
//   rsp_ready  in   1   initiator takes the response
//   rsp_rdata  out 32   load data, 0 for stores and errors
//   rsp_err    out  1   address was outside the memory window
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | req_ready high, waiting for a request
// WAIT   | request captured, counter running down to the access edge
// RESP   | access done, response held until rsp_ready

module ysyx_24100005_mem_responder #(
  parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         WORDS  = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [3:0]  cnt, cnt_nxt;
  logic        wen_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;
  logic [31:0] rdata_q, rdata_nxt;
  logic        err_q, err_nxt;
  logic        capture;
  logic        access;

  logic [31:0]           offset;
  logic                  in_window;
  logic [DEPTH_LOG2-1:0] idx;

  logic [31:0] mem [WORDS];

  // Unsigned wrap makes addresses below ADDR_BASE look huge, so a single
  // compare covers both window edges. 33 bits keeps the window size exact.
  assign offset    = addr_q - ADDR_BASE;
  assign in_window = ({1'b0, offset} < (33'd4 << DEPTH_LOG2));
  assign idx       = offset[DEPTH_LOG2+1:2];

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rdata_nxt = rdata_q;
    err_nxt   = err_q;
    capture   = 1'b0;
    access    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          capture   = 1'b1;
          cnt_nxt   = LAT_M1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          access    = 1'b1;
          state_nxt = S_RESP;
          err_nxt   = ~in_window;
          rdata_nxt = (in_window && !wen_q) ? mem[idx] : 32'd0;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_nxt = S_IDLE;
          rdata_nxt = 32'd0;
          err_nxt   = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wmask_q <= 4'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rdata_q <= rdata_nxt;
      err_q   <= err_nxt;
      if (capture) begin
        wen_q   <= req_wen;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wmask_q <= req_wmask;
      end
    end
  end

  // Array is deliberately left out of reset. Reset holds the FSM in IDLE,
  // so access cannot fire while rst is high.
  always_ff @(posedge clk) begin
    if (access && wen_q && in_window) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule
